// File: rtl/global_branch_predictor_pkg.sv
// Shared definitions for the gshare global branch predictor: default sizes,
// 2-bit counter encodings and the saturating counter update.
package global_branch_predictor_pkg;

  localparam int GHR_W     = 8;
  localparam int PHT_DEPTH = 1 << GHR_W;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctrState_e;

  // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/global_branch_predictor_pht.sv
// Pattern history table of 2-bit saturating counters with one asynchronous
// read port and one resolution write port. Reads see the pre-update value
// because the write only lands at the clock edge.
module pht_2bit_table #(
  parameter int IDX_W = global_branch_predictor_pkg::GHR_W,
  parameter int DEPTH = global_branch_predictor_pkg::PHT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [1:0]       rdCtr,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic             wrTaken
);
  import global_branch_predictor_pkg::*;

  logic [1:0] ctrTable [DEPTH];

  assign rdCtr = ctrTable[rdIdx];

  // Reset every counter to weakly-not-taken; otherwise step the resolved entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ctrTable[i] <= WNT;
    end else if (wrEn) begin
      ctrTable[wrIdx] <= satUpdate(ctrTable[wrIdx], wrTaken);
    end
  end

endmodule

// File: rtl/global_branch_predictor.sv
// Gshare global branch predictor: PC bits XOR speculative history index the
// PHT, the prediction is registered into decode, and the speculative history
// is repaired from the architectural history on a misprediction.
module global_branch_predictor #(
  parameter int GHR_W     = global_branch_predictor_pkg::GHR_W,
  parameter int PHT_DEPTH = global_branch_predictor_pkg::PHT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             branchD,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [GHR_W-1:0] res_idx,
  input  logic             res_mispred,
  output logic             pred_takeD,
  output logic [GHR_W-1:0] pred_idxD,
  output logic [GHR_W-1:0] ghr_spec
);
  import global_branch_predictor_pkg::*;

  logic [GHR_W-1:0] idxF;
  logic [1:0]       ctrF;
  logic [GHR_W-1:0] ghrArch;

  // Fetch stage: gshare hash of word-aligned PC bits and speculative history
  assign idxF = pcF[GHR_W+1:2] ^ ghr_spec;

  pht_2bit_table #(
    .IDX_W (GHR_W),
    .DEPTH (PHT_DEPTH)
  ) uPht (
    .clk     (clk),
    .rst     (rst),
    .rdIdx   (idxF),
    .rdCtr   (ctrF),
    .wrEn    (res_valid),
    .wrIdx   (res_idx),
    .wrTaken (res_taken)
  );

  // F->D prediction register: flush clears, stall holds, otherwise load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pred_takeD <= 1'b0;
      pred_idxD  <= '0;
    end else if (flushD) begin
      pred_takeD <= 1'b0;
      pred_idxD  <= '0;
    end else if (!stallD) begin
      pred_takeD <= ctrF[1];
      pred_idxD  <= idxF;
    end
  end

  // Architectural history follows every resolved branch in order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghrArch <= '0;
    end else if (res_valid) begin
      ghrArch <= {ghrArch[GHR_W-2:0], res_taken};
    end
  end

  // Speculative history: misprediction repair wins over a decode-stage shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_spec <= '0;
    end else if (res_valid && res_mispred) begin
      ghr_spec <= {ghrArch[GHR_W-2:0], res_taken};
    end else if (branchD && !stallD && !flushD) begin
      ghr_spec <= {ghr_spec[GHR_W-2:0], pred_takeD};
    end
  end

endmodule

// File: tb/tb_global_branch_predictor.sv
// Scoreboard bench for global_branch_predictor: a behavioural model predicts
// pred_takeD, pred_idxD and ghr_spec for every cycle; a monitor compares.
module tb_global_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        stallD, flushD, branchD;
  logic        res_valid, res_taken, res_mispred;
  logic [7:0]  res_idx;
  logic        pred_takeD;
  logic [7:0]  pred_idxD;
  logic [7:0]  ghr_spec;

  global_branch_predictor #(.GHR_W(8), .PHT_DEPTH(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .pcF         (pcF),
    .stallD      (stallD),
    .flushD      (flushD),
    .branchD     (branchD),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .res_idx     (res_idx),
    .res_mispred (res_mispred),
    .pred_takeD  (pred_takeD),
    .pred_idxD   (pred_idxD),
    .ghr_spec    (ghr_spec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       take;
    bit [7:0] idx;
    bit [7:0] ghr;
    string    tag;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int       mPht [256];
  bit [7:0] mSpec, mArch, mIdx;
  bit       mTake;

  // Monitor: one expected record per clock edge, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (pred_takeD !== e.take) begin
          errors++;
          $display("FAIL %s pred_takeD: got %0b expected %0b", e.tag, pred_takeD, e.take);
        end
        checks++;
        if (pred_idxD !== e.idx) begin
          errors++;
          $display("FAIL %s pred_idxD: got %02h expected %02h", e.tag, pred_idxD, e.idx);
        end
        checks++;
        if (ghr_spec !== e.ghr) begin
          errors++;
          $display("FAIL %s ghr_spec: got %02h expected %02h", e.tag, ghr_spec, e.ghr);
        end
      end
    end
  end

  // Drive one cycle of stimulus and push the model's view of the next state.
  task automatic step(input string tag, input bit r, input bit [31:0] pc,
                      input bit st, input bit fl, input bit br,
                      input bit rv, input bit rt, input bit [7:0] ri, input bit rm);
    bit [7:0] idx, nSpec, nIdx;
    bit       nTake;
    exp_t     e;
    @(negedge clk);
    rst = r; pcF = pc; stallD = st; flushD = fl; branchD = br;
    res_valid = rv; res_taken = rt; res_idx = ri; res_mispred = rm;

    idx = pc[9:2] ^ mSpec;
    if (!r) begin
      foreach (mPht[i]) mPht[i] = 1;
      mSpec = 8'h00; mArch = 8'h00; mTake = 1'b0; mIdx = 8'h00;
    end else begin
      nTake = mTake; nIdx = mIdx;
      if (fl) begin
        nTake = 1'b0; nIdx = 8'h00;
      end else if (!st) begin
        nTake = (mPht[idx] >= 2);
        nIdx  = idx;
      end
      nSpec = mSpec;
      if (rv && rm)             nSpec = {mArch[6:0], rt};
      else if (br && !st && !fl) nSpec = {mSpec[6:0], mTake};
      if (rv) begin
        mArch = {mArch[6:0], rt};
        if (rt && mPht[ri] < 3)  mPht[ri] = mPht[ri] + 1;
        if (!rt && mPht[ri] > 0) mPht[ri] = mPht[ri] - 1;
      end
      mTake = nTake; mIdx = nIdx; mSpec = nSpec;
    end
    e.take = mTake; e.idx = mIdx; e.ghr = mSpec; e.tag = tag;
    expQ.push_back(e);
  endtask

  initial begin
    rst = 1'b0; pcF = '0; stallD = 0; flushD = 0; branchD = 0;
    res_valid = 0; res_taken = 0; res_idx = '0; res_mispred = 0;
    foreach (mPht[i]) mPht[i] = 0;
    mSpec = 0; mArch = 0; mIdx = 0; mTake = 0;

    // Reset and first lookup after release
    step("reset0", 0, 32'h0, 0, 0, 0, 0, 0, 8'h00, 0);
    step("reset1", 0, 32'h0, 0, 0, 0, 0, 0, 8'h00, 0);
    step("firstLookup", 1, 32'h0000_0040, 0, 0, 0, 0, 0, 8'h00, 0);

    // Train idx 0x10 to strongly taken, then look it up
    step("train1", 1, 32'h0000_0000, 0, 0, 0, 1, 1, 8'h10, 0);
    step("train2", 1, 32'h0000_0000, 0, 0, 0, 1, 1, 8'h10, 0);
    step("trainedLookup", 1, 32'h0000_0040, 0, 0, 0, 0, 0, 8'h00, 0);

    // Flush beats stall, then a 3-cycle stall holds the register
    step("flushStall", 1, 32'h0000_0040, 1, 1, 0, 0, 0, 8'h00, 0);
    step("reload", 1, 32'h0000_0040, 0, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++)
      step("stallHold", 1, 32'h0000_0120 + 32'(i * 4), 1, 0, 0, 0, 0, 8'h00, 0);

    // Same-cycle lookup and update at idx 0x22 (ghr_spec is 0 here)
    step("rbwLookup", 1, 32'h0000_0088, 0, 0, 0, 1, 1, 8'h22, 0);
    step("rbwAfter", 1, 32'h0000_0088, 0, 0, 0, 0, 0, 8'h00, 0);

    // Build ghr_arch = 0x05, then recovery racing a decode shift
    step("reset2", 0, 32'h0, 0, 0, 0, 0, 0, 8'h00, 0);
    step("arch1", 1, 32'h0, 0, 0, 0, 1, 1, 8'h33, 0);
    step("arch0", 1, 32'h0, 0, 0, 0, 1, 0, 8'h34, 0);
    step("arch1b", 1, 32'h0, 0, 0, 0, 1, 1, 8'h35, 0);
    step("specShift", 1, 32'h0, 0, 0, 1, 0, 0, 8'h00, 0);
    step("recovery", 1, 32'h0000_0040, 0, 0, 1, 1, 1, 8'h36, 1);

    // Reset while a resolution is in flight
    step("resetMid", 0, 32'h0, 0, 0, 1, 1, 1, 8'h10, 1);
    step("postReset", 1, 32'h0000_0040, 0, 0, 0, 0, 0, 8'h00, 0);

    // Randomized traffic over a narrow PC/index window to force aliasing
    for (int i = 0; i < 600; i++) begin
      bit r, st, fl, br, rv, rt, rm;
      bit [31:0] pc;
      bit [7:0]  ri;
      r  = ($urandom_range(0, 59) != 0);
      pc = {22'($urandom), 4'($urandom), 6'($urandom)} & 32'h0000_00FC;
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 6) == 0);
      br = ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 2) != 0);
      rt = ($urandom_range(0, 2) != 0);
      ri = 8'($urandom_range(0, 15)) ^ 8'h3C;
      rm = ($urandom_range(0, 3) == 0);
      step("random", r, pc, st, fl, br, rv, rt, ri, rm);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
